// File: rtl/pwm_ramp_seq_if.sv
// pwm_ramp_seq_if: Avalon-MM CSR bus between the ramp sequencer and the PWM slave.
interface pwm_ramp_seq_if;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master (output chipselect, write, read, address, writedata, input readdata);
    modport slave  (input chipselect, write, read, address, writedata, output readdata);
endinterface

// File: rtl/pwm_ramp_seq.sv
// pwm_ramp_seq: Avalon-MM master that programs the PWM CSR block and ramps its duty cycle.
module pwm_ramp_seq #(
    parameter int         POLL_MAX        = 8,
    parameter logic [2:0] ADDR_CONTROL    = 3'd0,
    parameter logic [2:0] ADDR_STATUS     = 3'd1,
    parameter logic [2:0] ADDR_PERIOD     = 3'd2,
    parameter logic [2:0] ADDR_DUTY_CYCLE = 3'd3,
    parameter logic [2:0] ADDR_DIVISOR    = 3'd4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic [15:0]           cfg_prescaler,
    input  logic [15:0]           cfg_period,
    input  logic [15:0]           duty_start,
    input  logic [15:0]           duty_end,
    input  logic [15:0]           duty_step,
    input  logic [15:0]           dwell,
    pwm_ramp_seq_if.master        csr,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           cur_duty
);
    typedef enum logic [3:0] {IDLE, WR_DIV, WR_PER, WR_DUTY0, WR_EN, RD_STAT, CHK, DWELL, STEP, HOLD, WR_DIS} state_t;
    localparam int PW = $clog2(POLL_MAX + 1);
    state_t state, nxt;
    logic [PW-1:0] poll_cnt;
    logic [15:0] per, ds, de, st, dw, dwell_cnt, nd;
    logic [16:0] sum, dif;
    logic up, go, tmo, dw_done, wr_n, cs_n;
    logic [2:0] a_n;
    logic [31:0] d_n;
    always_comb begin
        go = state == IDLE && start && !stop;
        sum = {1'b0, cur_duty} + {1'b0, st};
        dif = {1'b0, cur_duty} - {1'b0, st};
        nd = st == 16'd0 ? de
           : up ? ((sum[16] || sum[15:0] > de) ? de : sum[15:0])
           : ((dif[16] || dif[15:0] < de) ? de : dif[15:0]);
        tmo = state == CHK && !csr.readdata[0] && poll_cnt == PW'(POLL_MAX - 1);
        dw_done = dwell_cnt == (dw == 16'd0 ? 16'd0 : dw - 16'd1);
        nxt = state;
        case (state)
            IDLE:     nxt = go ? WR_DIV : IDLE;
            WR_DIV:   nxt = WR_PER;
            WR_PER:   nxt = WR_DUTY0;
            WR_DUTY0: nxt = WR_EN;
            WR_EN:    nxt = RD_STAT;
            RD_STAT:  nxt = CHK;
            CHK:      nxt = csr.readdata[0] ? (cur_duty == de ? HOLD : DWELL) : (tmo ? WR_DIS : RD_STAT);
            DWELL:    nxt = dw_done ? STEP : DWELL;
            STEP:     nxt = cur_duty == de ? HOLD : DWELL;
            WR_DIS:   nxt = IDLE;
            default:  nxt = state;
        endcase
        if (stop && state != IDLE && state != WR_DIS) nxt = WR_DIS;
        wr_n = nxt inside {WR_DIV, WR_PER, WR_DUTY0, WR_EN, STEP, WR_DIS};
        cs_n = wr_n || nxt == RD_STAT;
        a_n = 3'd0;
        d_n = 32'd0;
        case (nxt)
            WR_DIV:   begin a_n = ADDR_DIVISOR;    d_n = {16'd0, cfg_prescaler}; end
            WR_PER:   begin a_n = ADDR_PERIOD;     d_n = {16'd0, per}; end
            WR_DUTY0: begin a_n = ADDR_DUTY_CYCLE; d_n = {16'd0, ds}; end
            WR_EN:    begin a_n = ADDR_CONTROL;    d_n = 32'd1; end
            RD_STAT:  a_n = ADDR_STATUS;
            STEP:     begin a_n = ADDR_DUTY_CYCLE; d_n = {16'd0, nd}; end
            WR_DIS:   a_n = ADDR_CONTROL;
            default:  ;
        endcase
    end
    // Bus outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            csr.chipselect <= 1'b0;
            csr.write <= 1'b0;
            csr.read <= 1'b0;
            csr.address <= 3'd0;
            csr.writedata <= 32'd0;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            cur_duty <= 16'd0;
            poll_cnt <= '0;
            dwell_cnt <= 16'd0;
            per <= 16'd0;
            ds <= 16'd0;
            de <= 16'd0;
            st <= 16'd0;
            dw <= 16'd0;
            up <= 1'b0;
        end else begin
            state <= nxt;
            csr.chipselect <= cs_n;
            csr.write <= wr_n;
            csr.read <= nxt == RD_STAT;
            csr.address <= a_n;
            csr.writedata <= d_n;
            busy <= nxt != IDLE;
            done <= nxt == HOLD;
            dwell_cnt <= state == DWELL ? dwell_cnt + 16'd1 : 16'd0;
            if (state == CHK && !csr.readdata[0]) poll_cnt <= poll_cnt + 1'b1;
            if (tmo) err <= 1'b1;
            if (nxt == WR_DUTY0) cur_duty <= ds;
            if (nxt == STEP) cur_duty <= nd;
            if (go) begin
                per <= cfg_period;
                ds <= duty_start;
                de <= duty_end;
                st <= duty_step;
                dw <= dwell;
                up <= duty_end >= duty_start;
                err <= 1'b0;
                poll_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_pwm_ramp_seq.sv
// tb_pwm_ramp_seq: directed bench with a bus-transaction scoreboard and a registered status slave.
module tb_pwm_ramp_seq;
    localparam logic [2:0] A_CTRL = 3'd0, A_STAT = 3'd1, A_PER = 3'd2, A_DUTY = 3'd3, A_DIV = 3'd4;
    typedef struct {logic w; logic [2:0] a; logic [31:0] d; int at;} txn_t;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, stat = 1'b0;
    logic [15:0] cfg_prescaler = 0, cfg_period = 0, duty_start = 0, duty_end = 0, duty_step = 0, dwell = 0;
    logic busy, done, err;
    logic [15:0] cur_duty;
    int tests = 0, fails = 0, cyc = 0, t0, ts;
    txn_t sbq[$];
    pwm_ramp_seq_if bus();
    pwm_ramp_seq #(.POLL_MAX(8)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .cfg_prescaler(cfg_prescaler), .cfg_period(cfg_period),
        .duty_start(duty_start), .duty_end(duty_end), .duty_step(duty_step), .dwell(dwell),
        .csr(bus), .busy(busy), .done(done), .err(err), .cur_duty(cur_duty)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bus.readdata <= bus.read ? {31'd0, stat} : 32'd0;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // Every bus cycle is popped against the scoreboard, including its cycle stamp.
    always @(negedge clk) begin
        txn_t e;
        if (!reset) begin
            if (bus.chipselect) begin
                if (sbq.size() == 0) check("sb_extra_cs", bus.chipselect, 0);
                else begin
                    e = sbq.pop_front();
                    check("bus_wr", bus.write, e.w);
                    check("bus_rd", bus.read, !e.w);
                    check("bus_addr", bus.address, e.a);
                    if (e.w) check("bus_data", bus.writedata, e.d);
                    check("bus_cyc", cyc, e.at);
                end
            end else check("bus_idle", {bus.write, bus.read, bus.address, bus.writedata}, 0);
        end
    end
    task automatic push(input logic w, input logic [2:0] a, input logic [31:0] d, input int at);
        sbq.push_back('{w, a, d, at});
    endtask
    task automatic cfg(input logic [15:0] p, pe, s, e, st, dw);
        cfg_prescaler = p; cfg_period = pe; duty_start = s; duty_end = e; duty_step = st; dwell = dw;
    endtask
    task automatic go();
        @(negedge clk);
        t0 = cyc;
        push(1, A_DIV, {16'd0, cfg_prescaler}, t0 + 1);
        push(1, A_PER, {16'd0, cfg_period}, t0 + 2);
        push(1, A_DUTY, {16'd0, duty_start}, t0 + 3);
        push(1, A_CTRL, 1, t0 + 4);
        push(0, A_STAT, 0, t0 + 5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask
    task automatic wait_done();
        for (int i = 0; i < 200 && !done; i++) @(negedge clk);
        check("done", done, 1);
    endtask
    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        check("idle", busy, 0);
    endtask
    task automatic stop_seq();
        @(negedge clk);
        ts = cyc;
        push(1, A_CTRL, 0, ts + 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle();
        check("sb_empty", sbq.size(), 0);
    endtask
    task automatic up_ramp();
        cfg(4, 100, 10, 40, 10, 3);
        stat = 1'b1;
        go();
        push(1, A_DUTY, 20, t0 + 10);
        push(1, A_DUTY, 30, t0 + 14);
        push(1, A_DUTY, 40, t0 + 18);
        wait_done();
        check("up_cur", cur_duty, 40);
        check("up_busy", busy, 1);
        check("up_sb", sbq.size(), 0);
        stop_seq();
        check("up_done_clr", done, 0);
    endtask
    initial begin
        repeat (3) @(negedge clk);
        check("rst_bus", {bus.chipselect, bus.write, bus.read, bus.address, bus.writedata}, 0);
        check("rst_st", {busy, done, err, cur_duty}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        up_ramp();
        cfg(1, 200, 50, 5, 20, 0);
        go();
        push(1, A_DUTY, 30, t0 + 8);
        push(1, A_DUTY, 10, t0 + 10);
        push(1, A_DUTY, 5, t0 + 12);
        wait_done();
        check("dn_cur", cur_duty, 5);
        stop_seq();
        cfg(2, 300, 16'hFFF0, 16'hFFFF, 16'h0020, 2);
        go();
        push(1, A_DUTY, 16'hFFFF, t0 + 9);
        wait_done();
        check("ovf_cur", cur_duty, 16'hFFFF);
        stop_seq();
        stat = 1'b0;
        cfg(3, 50, 7, 9, 1, 1);
        go();
        for (int k = 1; k < 8; k++) push(0, A_STAT, 0, t0 + 5 + 2 * k);
        push(1, A_CTRL, 0, t0 + 21);
        wait_idle();
        check("tmo_err", err, 1);
        check("tmo_sb", sbq.size(), 0);
        check("tmo_at", cyc, t0 + 22);
        stat = 1'b1;
        cfg(5, 60, 30, 30, 4, 2);
        go();
        check("err_clr", err, 0);
        wait_done();
        check("eq_cur", cur_duty, 30);
        check("eq_at", cyc, t0 + 7);
        stop_seq();
        cfg(4, 100, 5, 100, 10, 10);
        go();
        repeat (7) @(negedge clk);
        check("dw_busy", busy, 1);
        stop_seq();
        check("dw_cur", cur_duty, 5);
        check("dw_at", cyc, ts + 2);
        repeat (15) @(negedge clk);
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        repeat (5) @(negedge clk);
        check("ss_busy", busy, 0);
        cfg(4, 100, 10, 40, 10, 3);
        @(negedge clk);
        t0 = cyc;
        push(1, A_DIV, 4, t0 + 1);
        push(1, A_PER, 100, t0 + 2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_bus", {bus.chipselect, bus.write, bus.read, bus.address, bus.writedata}, 0);
        check("mid_rst_st", {busy, done, cur_duty}, 0);
        check("mid_rst_sb", sbq.size(), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        up_ramp();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pwm_ramp_seq.md
Name: pwm_ramp_seq

Overview:
- Avalon-MM master sequencer that programs and drives the PWM CSR slave: control, status, period, duty_cycle and divisor registers.
- On `start` it:
  - writes divisor, period and the initial duty, then sets enable;
  - polls status until `pwm_running` reads 1;
  - ramps duty_cycle from `duty_start` to `duty_end` in steps of `duty_step`, with `dwell` clocks between writes.
- Sits between a host/GPIO start interface and the PWM CSR port, so soft-start/fade runs with no CPU involvement.

Parameters:
- POLL_MAX, 8, maximum status reads before declaring error (>=1).
- ADDR_CONTROL, 3'd0, CSR control register address.
- ADDR_STATUS, 3'd1, CSR status register address.
- ADDR_PERIOD, 3'd2, CSR period register address.
- ADDR_DUTY_CYCLE, 3'd3, CSR duty_cycle register address.
- ADDR_DIVISOR, 3'd4, CSR divisor register address.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begin sequence (honoured in IDLE only).
- stop  in  1  one-cycle pulse; disable PWM and abort.
- cfg_prescaler  in  16  divisor value to program.
- cfg_period  in  16  period value to program.
- duty_start  in  16  first duty written.
- duty_end  in  16  final duty value.
- duty_step  in  16  ramp increment magnitude.
- dwell  in  16  clocks between duty updates.
- chipselect  out  1  Avalon chip select to CSR.
- write  out  1  Avalon write strobe.
- read  out  1  Avalon read strobe.
- address  out  3  Avalon register address.
- writedata  out  32  Avalon write data.
- readdata  in  32  Avalon read data, registered by the slave (valid the cycle after `read`).
- busy  out  1  high in every state except IDLE.
- done  out  1  high in HOLD (ramp complete, PWM enabled).
- err  out  1  sticky status-poll timeout; cleared by the next accepted start.
- cur_duty  out  16  last duty value written.

Behaviour:
- Reset values: all outputs 0; state IDLE; latched config 0; poll counter 0.
- Config latch: on an accepted start, latch all `cfg_*`, `duty_*` and `dwell` inputs and clear `err`. Inputs are ignored after that until IDLE is re-entered.
- Write states: each write state lasts exactly one cycle with chipselect=1, write=1, read=0. Unused writedata bits are 0. No waitrequest exists.
- Read state: chipselect=1, read=1 for one cycle; `readdata[0]` is sampled in the following CHK cycle.
- Outside write/read states: chipselect, write and read are 0; address and writedata are 0.
- States and transitions:
  - IDLE: wait for start.
  - WR_DIV: write cfg_prescaler to ADDR_DIVISOR.
  - WR_PER: write cfg_period to ADDR_PERIOD.
  - WR_DUTY0: write duty_start to ADDR_DUTY_CYCLE; cur_duty<=duty_start.
  - WR_EN: write 32'h1 to ADDR_CONTROL.
  - RD_STAT: read ADDR_STATUS.
  - CHK:
    - readdata[0]=1 -> DWELL, or HOLD if cur_duty==duty_end.
    - readdata[0]=0 -> poll counter +1. If count==POLL_MAX: err<=1 and go to WR_DIS; else back to RD_STAT.
  - DWELL: counter runs for max(dwell,1) cycles, then STEP.
  - STEP: write next duty to ADDR_DUTY_CYCLE and update cur_duty. Then HOLD if next==duty_end, else DWELL.
  - HOLD: wait for stop.
  - WR_DIS: write 32'h0 to ADDR_CONTROL, then IDLE.
- Cycle timing: start sampled at cycle 0 gives DIV write at 1, PER at 2, DUTY0 at 3, EN at 4, status read at 5, check at 6.
- Direction: up if duty_end>=duty_start, else down. Computed once at latch.
- Next duty, using 17-bit arithmetic:
  - Up: cur+step. If the result is >duty_end or overflows 16 bits, clamp to duty_end.
  - Down: cur-step. If it borrows or is <duty_end, clamp to duty_end.
  - duty_step==0: next=duty_end (single jump).
- duty_start==duty_end: no STEP occurs; CHK goes straight to HOLD.
- stop handling:
  - In any state other than IDLE and WR_DIS, stop forces the next state to WR_DIS. A write issued in the current cycle still completes.
  - stop in IDLE is ignored.
  - start and stop together in IDLE: stop wins, no sequence begins.
  - start while busy is ignored.
- Reset mid-sequence: bus strobes drop to 0 immediately (asynchronous reset); no disable write is issued.

Test Plan:
- Up ramp:
  - Stimulus: prescaler=4, period=100, start=10, end=40, step=10, dwell=3, status reads 1.
  - Required response: writes DIV=4, PER=100, DUTY=10, CTRL=1; one read; then DUTY=20/30/40 spaced 4 cycles apart (3 dwell + STEP). done=1, cur_duty=40.
- Down ramp with clamp:
  - Stimulus: start=50, end=5, step=20.
  - Required response: duty writes 50, 30, 10, 5; done=1.
- Overflow clamp:
  - Stimulus: start=16'hFFF0, end=16'hFFFF, step=16'h0020.
  - Required response: single STEP write of 16'hFFFF.
- Poll timeout:
  - Stimulus: status held at 0, POLL_MAX=8.
  - Required response: exactly 8 status reads, err=1, then CTRL=0 written, IDLE with busy=0. The next start clears err.
- Stop during DWELL:
  - Stimulus: stop asserted during DWELL.
  - Required response: next cycle writes CTRL=0, then IDLE; no further duty writes. start with stop together in IDLE produces no bus activity.
- Reset mid-sequence:
  - Stimulus: reset asserted during WR_PER.
  - Required response: all outputs 0 immediately. A fresh start replays the full sequence from WR_DIV.
